// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: registered, handshaked ALU control stage between decode and execute.
// Define ALU_CTRL_MUL_EN to build the multi-cycle multiply (MUL state and beat counter).
module alu_ctrl_seq #(
    parameter int MUL_CYCLES = 16,
    parameter int CNT_W      = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [4:0] aluOp,
    input  logic [1:0] funct,
    input  logic       flush,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       invA,
    output logic       invB,
    output logic       sign,
    output logic       cin,
    output logic       passB,
    output logic [2:0] aluControl,
    output logic       mulStep,
    output logic       mulLast,
    output logic       illegal
);

    if (MUL_CYCLES < 2 || (2 ** CNT_W) < MUL_CYCLES) begin : gBadParams
        $error("alu_ctrl_seq: MUL_CYCLES must be >= 2 and representable in CNT_W bits");
    end

    typedef enum logic [1:0] {
        IDLE,
        HOLD
`ifdef ALU_CTRL_MUL_EN
        , MUL
`endif
    } stateT;

    typedef struct packed {
        logic       invA;
        logic       invB;
        logic       sign;
        logic       cin;
        logic       passB;
        logic [2:0] aluControl;
        logic       illegal;
    } ctrlT;

    function automatic ctrlT decode(input logic [4:0] op, input logic [1:0] fn);
        ctrlT c;
        c = '0;
        case (op)
            5'b10000, 5'b10001, 5'b10011, 5'b11001, 5'b11111: c.aluControl = 3'b100;
            5'b01000: begin c.sign = 1'b1; c.aluControl = 3'b100; end
            5'b01001, 5'b11100: begin c.invA = 1'b1; c.cin = 1'b1; c.aluControl = 3'b100; end
            5'b11101, 5'b11110, 5'b01110, 5'b01111: begin
                c.sign = 1'b1; c.invB = 1'b1; c.cin = 1'b1; c.aluControl = 3'b100;
            end
            5'b01010: c.aluControl = 3'b110;
            5'b01011: begin c.invB = 1'b1; c.aluControl = 3'b111; end
            5'b10100, 5'b10101, 5'b10110, 5'b10111: c.aluControl = {1'b0, op[1:0]};
            5'b11010: c.aluControl = {1'b0, fn};
            5'b11011: begin
                case (fn)
                    2'b00: c.aluControl = 3'b100;
                    2'b01: begin c.invA = 1'b1; c.cin = 1'b1; c.aluControl = 3'b100; end
                    2'b10: c.aluControl = 3'b110;
                    2'b11: begin c.invB = 1'b1; c.aluControl = 3'b111; end
                endcase
            end
            5'b11000: c.passB = 1'b1;
            5'b10010: c.aluControl = 3'b101;
`ifdef ALU_CTRL_MUL_EN
            5'b00110: begin c.sign = 1'b1; c.aluControl = 3'b100; end
`endif
            5'b00000, 5'b00001: c = '0;
            default: c.illegal = 1'b1;
        endcase
        return c;
    endfunction

    stateT state;
    ctrlT  ctrl;
    ctrlT  newCtrl;
    logic  accept;

    assign newCtrl   = decode(aluOp, funct);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state != IDLE);
    assign {invA, invB, sign, cin, passB, aluControl, illegal} = ctrl;

`ifdef ALU_CTRL_MUL_EN
    logic [CNT_W-1:0] cnt;
    logic             lastQ;
    logic             isMul;

    assign isMul   = (aluOp == 5'b00110);
    assign mulStep = (state == MUL);
    assign mulLast = lastQ;

    // A held word may be replaced only on its final handshake, which is what lets ops stream back-to-back.
    always_comb begin
        in_ready = 1'b0;
        if (!flush) begin
            case (state)
                IDLE:    in_ready = 1'b1;
                HOLD:    in_ready = out_ready;
                MUL:     in_ready = out_ready && lastQ;
                default: in_ready = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst || flush) begin
            state <= IDLE;
            ctrl  <= '0;
            cnt   <= '0;
            lastQ <= 1'b0;
        end else if (accept) begin
            state <= isMul ? MUL : HOLD;
            ctrl  <= newCtrl;
            cnt   <= '0;
            lastQ <= 1'b0;
        end else if (out_valid && out_ready) begin
            if (state == MUL && !lastQ) begin
                cnt   <= cnt + CNT_W'(1);
                lastQ <= (cnt + CNT_W'(1)) == CNT_W'(MUL_CYCLES - 1);
            end else begin
                state <= IDLE;
                ctrl  <= '0;
                cnt   <= '0;
                lastQ <= 1'b0;
            end
        end
    end
`else
    assign mulStep = 1'b0;
    assign mulLast = 1'b0;

    always_comb begin
        in_ready = 1'b0;
        if (!flush) begin
            case (state)
                IDLE:    in_ready = 1'b1;
                HOLD:    in_ready = out_ready;
                default: in_ready = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst || flush) begin
            state <= IDLE;
            ctrl  <= '0;
        end else if (accept) begin
            state <= HOLD;
            ctrl  <= newCtrl;
        end else if (out_valid && out_ready) begin
            state <= IDLE;
            ctrl  <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Testbench for alu_ctrl_seq: a beat-queue model of the stage plus directed vectors with literal expectations.
// Works with ALU_CTRL_MUL_EN either defined or undefined.
`timescale 1ns/1ps
module tb_alu_ctrl_seq;

    localparam int MC = 16;
`ifdef ALU_CTRL_MUL_EN
    localparam bit MulEn = 1'b1;
`else
    localparam bit MulEn = 1'b0;
`endif

    // Word layout: {invA, invB, sign, cin, passB, aluControl[2:0], mulStep, mulLast, illegal}
    localparam logic [10:0] WordAdd  = 11'b00000_100_000;
    localparam logic [10:0] WordAddi = 11'b00100_100_000;
    localparam logic [10:0] WordSub  = 11'b10010_100_000;
    localparam logic [10:0] WordCmp  = 11'b01110_100_000;
    localparam logic [10:0] WordXor  = 11'b00000_110_000;
    localparam logic [10:0] WordAndn = 11'b01000_111_000;
    localparam logic [10:0] WordLbi  = 11'b00001_000_000;
    localparam logic [10:0] WordSlbi = 11'b00000_101_000;
    localparam logic [10:0] WordMul  = 11'b00100_100_100;
    localparam logic [10:0] WordIll  = 11'b00000_000_001;
    localparam logic [10:0] LastBit  = 11'b00000_000_010;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [4:0] aluOp = '0;
    logic [1:0] funct = '0;
    logic       flush = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       invA, invB, sign, cin, passB;
    logic [2:0] aluControl;
    logic       mulStep, mulLast, illegal;

    int checks = 0;
    int errors = 0;
    logic [10:0] expQ[$];
    logic        mdlRdy;
    logic        expRdy;
    int          cycles;
    logic        accepted;

    alu_ctrl_seq #(.MUL_CYCLES(MC), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .aluOp(aluOp), .funct(funct), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .invA(invA), .invB(invB), .sign(sign), .cin(cin), .passB(passB),
        .aluControl(aluControl), .mulStep(mulStep), .mulLast(mulLast), .illegal(illegal)
    );

    always #5 clk = ~clk;

    function automatic logic [10:0] gotWord();
        return {invA, invB, sign, cin, passB, aluControl, mulStep, mulLast, illegal};
    endfunction

    function automatic logic [10:0] expWord(input logic [4:0] op, input logic [1:0] fn);
        logic [10:0] w;
        w = WordIll;
        case (op)
            5'b10000, 5'b10001, 5'b10011, 5'b11001, 5'b11111: w = WordAdd;
            5'b01000: w = WordAddi;
            5'b01001, 5'b11100: w = WordSub;
            5'b11101, 5'b11110, 5'b01110, 5'b01111: w = WordCmp;
            5'b01010: w = WordXor;
            5'b01011: w = WordAndn;
            5'b10100, 5'b10101, 5'b10110, 5'b10111: w = 11'(op[1:0]) << 3;
            5'b11010: w = 11'(fn) << 3;
            5'b11011: w = (fn == 2'd0) ? WordAdd : (fn == 2'd1) ? WordSub : (fn == 2'd2) ? WordXor : WordAndn;
            5'b11000: w = WordLbi;
            5'b10010: w = WordSlbi;
            5'b00000, 5'b00001: w = '0;
            5'b00110: w = MulEn ? WordMul : WordIll;
            default: w = WordIll;
        endcase
        return w;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h at %0t", name, got, want, $time);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [4:0] op, input logic [1:0] fn,
                                 input logic ordy, input logic fl);
        in_valid  = v;
        aluOp     = op;
        funct     = fn;
        out_ready = ordy;
        flush     = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model: a queue of beats still to be presented; one op expands to one beat, or MC beats for mul.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            expQ.delete();
        end else begin
            mdlRdy = !flush && (expQ.size() == 0 || (expQ.size() == 1 && out_ready));
            if (flush) begin
                expQ.delete();
            end else begin
                if (expQ.size() > 0 && out_ready) void'(expQ.pop_front());
                if (in_valid && mdlRdy) begin
                    if (MulEn && aluOp == 5'b00110) begin
                        for (int b = 1; b <= MC; b++) expQ.push_back(WordMul | ((b == MC) ? LastBit : 11'd0));
                    end else begin
                        expQ.push_back(expWord(aluOp, funct));
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        expRdy = !flush && (expQ.size() == 0 || (expQ.size() == 1 && out_ready));
        checkOutput("model out_valid", out_valid, expQ.size() != 0);
        checkOutput("model in_ready", in_ready, expRdy);
        if (expQ.size() != 0) checkOutput("model word", gotWord(), expQ[0]);
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, errors so far %0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        applyStimulus(0, 5'd0, 2'd0, 0, 0);
        repeat (2) tick();
        checkOutput("reset out_valid", out_valid, 0);
        checkOutput("reset word", gotWord(), 0);
        rst = 1'b0;
        #1;
        checkOutput("post-reset in_ready", in_ready, 1);

        // R-type subtract
        applyStimulus(1, 5'b11011, 2'b01, 1, 0);
        tick();
        checkOutput("rtype sub valid", out_valid, 1);
        checkOutput("rtype sub word", gotWord(), 11'b10010100000);
        applyStimulus(0, 5'd0, 2'd0, 1, 0);
        tick();
        checkOutput("rtype sub retired", out_valid, 0);

        // Backpressure on slt, then release together with xori
        applyStimulus(1, 5'b11101, 2'b00, 0, 0);
        tick();
        applyStimulus(0, 5'd0, 2'd0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            checkOutput("slt held word", gotWord(), 11'b01110100000);
            checkOutput("slt held in_ready", in_ready, 0);
            tick();
        end
        applyStimulus(1, 5'b01010, 2'b00, 1, 0);
        #1;
        checkOutput("slt release in_ready", in_ready, 1);
        tick();
        checkOutput("xori word", gotWord(), 11'b00000110000);
        applyStimulus(0, 5'd0, 2'd0, 1, 0);
        tick();
        checkOutput("xori retired", out_valid, 0);

`ifdef ALU_CTRL_MUL_EN
        // Full-rate multiply: MC beats, last one flagged
        applyStimulus(1, 5'b00110, 2'b00, 1, 0);
        tick();
        applyStimulus(0, 5'd0, 2'd0, 1, 0);
        for (int b = 1; b <= MC; b++) begin
            checkOutput($sformatf("mul beat %0d", b), {out_valid, mulStep, mulLast, in_ready},
                        {2'b11, (b == MC), (b == MC)});
            tick();
        end
        checkOutput("mul done", out_valid, 0);

        // Two stall cycles stretch the multiply to MC+2 cycles
        applyStimulus(1, 5'b00110, 2'b00, 1, 0);
        tick();
        cycles = 0;
        for (int c = 0; c < 40 && out_valid; c++) begin
            cycles++;
            applyStimulus(0, 5'd0, 2'd0, (c == 3 || c == 4) ? 1'b0 : 1'b1, 0);
            tick();
        end
        checkOutput("mul stretched cycles", cycles, MC + 2);

        // Next op accepted on the last multiply beat
        applyStimulus(1, 5'b00110, 2'b00, 1, 0);
        tick();
        applyStimulus(0, 5'd0, 2'd0, 1, 0);
        repeat (MC - 1) tick();
        applyStimulus(1, 5'b01000, 2'b00, 1, 0);
        tick();
        checkOutput("addi after mul word", {out_valid, gotWord()}, {1'b1, 11'b00100100000});
        applyStimulus(0, 5'd0, 2'd0, 1, 0);
        tick();

        // Flush on beat 5 of a multiply
        applyStimulus(1, 5'b00110, 2'b00, 1, 0);
        tick();
        applyStimulus(0, 5'd0, 2'd0, 1, 0);
        repeat (4) tick();
        checkOutput("beat 5 before flush", {mulStep, mulLast}, 2'b10);
`else
        // Flush of a held compare
        applyStimulus(1, 5'b11110, 2'b00, 0, 0);
        tick();
        applyStimulus(0, 5'd0, 2'd0, 0, 0);
        repeat (2) tick();
`endif
        applyStimulus(1, 5'b10000, 2'b00, 1, 1);
        tick();
        applyStimulus(1, 5'b01000, 2'b00, 1, 0);
        #1;
        checkOutput("flush out_valid", out_valid, 0);
        checkOutput("flush word", gotWord(), 0);
        checkOutput("flush in_ready", in_ready, 1);
        tick();
        checkOutput("addi after flush", {out_valid, gotWord()}, {1'b1, 11'b00100100000});
        applyStimulus(0, 5'd0, 2'd0, 1, 0);
        tick();

        // Unrecognised opcodes are single illegal beats
        applyStimulus(1, 5'b00010, 2'b00, 1, 0);
        tick();
        checkOutput("illegal 00010 word", gotWord(), 11'b00000000001);
        applyStimulus(0, 5'd0, 2'd0, 1, 0);
        tick();
        checkOutput("illegal 00010 single beat", out_valid, 0);
`ifndef ALU_CTRL_MUL_EN
        applyStimulus(1, 5'b00110, 2'b00, 1, 0);
        tick();
        checkOutput("mul disabled word", gotWord(), 11'b00000000001);
        applyStimulus(0, 5'd0, 2'd0, 1, 0);
        tick();
        checkOutput("mul disabled single beat", out_valid, 0);
`endif

        // Shift and lbi pins
        applyStimulus(1, 5'b10111, 2'b00, 1, 0);
        tick();
        checkOutput("srli word", gotWord(), 11'b00000011000);
        applyStimulus(1, 5'b11010, 2'b10, 1, 0);
        tick();
        checkOutput("rtype ror word", gotWord(), 11'b00000010000);
        applyStimulus(1, 5'b11000, 2'b11, 1, 0);
        tick();
        checkOutput("lbi word", gotWord(), 11'b00001000000);

        // Streaming sweep of every opcode, then every R-type funct
        for (int op = 0; op < 32; op++) begin
            applyStimulus(1, 5'(op), 2'(op * 3), 1, 0);
            accepted = 1'b0;
            for (int w = 0; w < 40 && !accepted; w++) begin
                #1;
                accepted = in_ready;
                tick();
            end
            if (!accepted) checkOutput("sweep accept timeout", 0, 1);
        end
        for (int fn = 0; fn < 4; fn++) begin
            applyStimulus(1, 5'b11011, 2'(fn), 1, 0);
            tick();
            applyStimulus(1, 5'b11010, 2'(fn), 1, 0);
            tick();
        end
        applyStimulus(0, 5'd0, 2'd0, 1, 0);
        tick();

        // Reset in the middle of a long op leaves nothing behind
        applyStimulus(1, MulEn ? 5'b00110 : 5'b11101, 2'b00, MulEn ? 1'b1 : 1'b0, 0);
        tick();
        applyStimulus(0, 5'd0, 2'd0, MulEn ? 1'b1 : 1'b0, 0);
        repeat (2) tick();
        rst = 1'b1;
        #1;
        checkOutput("mid reset out_valid", out_valid, 0);
        checkOutput("mid reset word", gotWord(), 0);
        tick();
        rst = 1'b0;
        applyStimulus(0, 5'd0, 2'd0, 1, 0);
        repeat (3) tick();
        checkOutput("no residual beats", out_valid, 0);

        repeat (2) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
